// File: rtl/reset_sequencer_pf.sv
// reset_sequencer_pf: fabric reset controller combining an external reset,
// device INIT_DONE and several PLL locks. It releases NUM_CH active-low
// fabric resets in a staggered order, pulls them all back on PLL lock loss,
// and provides a per-channel soft reset while running.
//
// Optional feature: define RSTSEQ_CAUSE_EN to add the o_rst_cause port
// (00 external/POR, 01 PLL lock loss, 10 soft reset).
//
// state         | meaning
// S_WAIT_INIT   | waiting for synchronised INIT_DONE (sticky once seen)
// S_WAIT_LOCK   | filtering combined PLL lock for LOCK_FILTER cycles
// S_HOLD        | all fabric resets held for HOLD_CYCLES after lock qualifies
// S_RELEASE     | channels released one by one, STAGGER_CYCLES apart
// S_RUN         | sequence complete, soft resets accepted

`timescale 1ns/1ps

module reset_sequencer_pf #(
    parameter int NUM_CH         = 4,
    parameter int NUM_PLL        = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_FILTER    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                i_clk,
    input  logic                i_ext_rst_n,
    input  logic                i_init_done,
    input  logic [NUM_PLL-1:0]  i_pll_lock,
    input  logic [NUM_CH-1:0]   i_sw_rst_req,
    output logic                o_pll_powerdown_b,
    output logic [NUM_CH-1:0]   o_fabric_reset_n,
    output logic                o_rst_done
`ifdef RSTSEQ_CAUSE_EN
    ,
    output logic [1:0]          o_rst_cause
`endif
);

    localparam int LW      = $clog2(LOCK_FILTER + 1);
    localparam int HW      = $clog2(HOLD_CYCLES + 1);
    localparam int REL_MAX = (NUM_CH - 1) * STAGGER_CYCLES;
    localparam int RW      = (REL_MAX > 0) ? $clog2(REL_MAX + 1) : 1;

    localparam logic [2:0] S_WAIT_INIT = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_HOLD      = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    logic [SYNC_STAGES-1:0]              r_rst_sync;
    logic [SYNC_STAGES-1:0]              r_init_sync;
    logic [SYNC_STAGES-1:0][NUM_PLL-1:0] r_lock_sync;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0]  r_sw_sync;
    logic [NUM_CH-1:0]                   r_sw_prev;

    logic                       w_run;
    logic                       w_init;
    logic                       w_lock;
    logic [NUM_CH-1:0]          w_sw;
    logic [NUM_CH-1:0]          w_sw_rise;

    logic [2:0]                 r_state,    w_state_nxt;
    logic [LW-1:0]              r_lock_cnt, w_lock_nxt;
    logic [HW-1:0]              r_hold_cnt, w_hold_nxt;
    logic [RW-1:0]              r_rel_cnt,  w_rel_nxt;
    logic [RW-1:0]              w_rel_inc;
    logic [NUM_CH-1:0][HW-1:0]  r_soft_cnt, w_soft_nxt;
    logic [NUM_CH-1:0]          r_fabric_n, w_fab_nxt;
    logic                       r_done,     w_done_nxt;
`ifdef RSTSEQ_CAUSE_EN
    logic [1:0]                 r_cause,    w_cause_nxt;
`endif

    assign w_run     = r_rst_sync[SYNC_STAGES-1];
    assign w_init    = r_init_sync[SYNC_STAGES-1];
    assign w_lock    = &r_lock_sync[SYNC_STAGES-1];
    assign w_sw      = r_sw_sync[SYNC_STAGES-1];
    assign w_sw_rise = w_sw & ~r_sw_prev;

    // Reset-release and async-input synchronisers; SW edges are tracked in every state.
    always_ff @(posedge i_clk or negedge i_ext_rst_n) begin
        if (!i_ext_rst_n) begin
            r_rst_sync  <= '0;
            r_init_sync <= '0;
            r_lock_sync <= '0;
            r_sw_sync   <= '0;
            r_sw_prev   <= '0;
        end else begin
            r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
            r_init_sync <= {r_init_sync[SYNC_STAGES-2:0], i_init_done};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], i_pll_lock};
            r_sw_sync   <= {r_sw_sync[SYNC_STAGES-2:0], i_sw_rst_req};
            r_sw_prev   <= w_sw;
        end
    end

    // Sequencer next-state: lock loss overrides everything below EXT_RST_N.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_rel_nxt   = r_rel_cnt;
        w_soft_nxt  = r_soft_cnt;
        w_fab_nxt   = r_fabric_n;
        w_done_nxt  = r_done;
`ifdef RSTSEQ_CAUSE_EN
        w_cause_nxt = r_cause;
`endif
        w_rel_inc   = (r_rel_cnt == RW'(REL_MAX)) ? r_rel_cnt : r_rel_cnt + RW'(1);

        if (w_run) begin
            case (r_state)
                S_WAIT_INIT: begin
                    if (w_init) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_lock_nxt  = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock) begin
                        if (r_lock_cnt < LW'(LOCK_FILTER))
                            w_lock_nxt = r_lock_cnt + LW'(1);
                        if (r_lock_cnt >= LW'(LOCK_FILTER - 1)) begin
                            w_state_nxt = S_HOLD;
                            w_hold_nxt  = HW'(HOLD_CYCLES - 1);
                        end
                    end else begin
                        w_lock_nxt = '0;
                    end
                end
                S_HOLD, S_RELEASE, S_RUN: begin
                    if (!w_lock) begin
                        w_state_nxt = S_WAIT_LOCK;
                        w_lock_nxt  = '0;
                        w_hold_nxt  = '0;
                        w_rel_nxt   = '0;
                        w_soft_nxt  = '0;
                        w_fab_nxt   = '0;
                        w_done_nxt  = 1'b0;
`ifdef RSTSEQ_CAUSE_EN
                        w_cause_nxt = 2'b01;
`endif
                    end else if (r_state == S_HOLD) begin
                        if (r_hold_cnt == '0) begin
                            // Channel 0 (and any channel with zero offset) rises on entry.
                            w_rel_nxt = '0;
                            for (int i = 0; i < NUM_CH; i++)
                                w_fab_nxt[i] = (i * STAGGER_CYCLES == 0);
                            if (REL_MAX == 0) begin
                                w_state_nxt = S_RUN;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_RELEASE;
                            end
                        end else begin
                            w_hold_nxt = r_hold_cnt - HW'(1);
                        end
                    end else if (r_state == S_RELEASE) begin
                        w_rel_nxt = w_rel_inc;
                        for (int i = 0; i < NUM_CH; i++)
                            if (i * STAGGER_CYCLES <= int'(w_rel_inc))
                                w_fab_nxt[i] = 1'b1;
                        if (int'(w_rel_inc) >= REL_MAX) begin
                            w_state_nxt = S_RUN;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        // Soft reset timers: loaded on a request edge, terminal count re-releases.
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (w_sw_rise[i]) begin
                                w_soft_nxt[i] = HW'(HOLD_CYCLES);
                                w_fab_nxt[i]  = 1'b0;
`ifdef RSTSEQ_CAUSE_EN
                                w_cause_nxt   = 2'b10;
`endif
                            end else if (r_soft_cnt[i] != '0) begin
                                w_soft_nxt[i] = r_soft_cnt[i] - HW'(1);
                                if (r_soft_cnt[i] == HW'(1))
                                    w_fab_nxt[i] = 1'b1;
                            end
                        end
                    end
                end
                default: w_state_nxt = S_WAIT_INIT;
            endcase
        end
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_ext_rst_n) begin
        if (!i_ext_rst_n) begin
            r_state    <= S_WAIT_INIT;
            r_lock_cnt <= '0;
            r_hold_cnt <= '0;
            r_rel_cnt  <= '0;
            r_soft_cnt <= '0;
            r_fabric_n <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_cnt <= w_lock_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rel_cnt  <= w_rel_nxt;
            r_soft_cnt <= w_soft_nxt;
            r_fabric_n <= w_fab_nxt;
            r_done     <= w_done_nxt;
        end
    end

`ifdef RSTSEQ_CAUSE_EN
    // Last reset cause; holds between events.
    always_ff @(posedge i_clk or negedge i_ext_rst_n) begin
        if (!i_ext_rst_n)
            r_cause <= 2'b00;
        else
            r_cause <= w_cause_nxt;
    end

    assign o_rst_cause = r_cause;
`endif

    // PLLs stay powered down until the internal reset has released.
    assign o_pll_powerdown_b = r_rst_sync[SYNC_STAGES-1];
    assign o_fabric_reset_n  = r_fabric_n;
    assign o_rst_done        = r_done;

endmodule

// File: tb/tb_reset_sequencer_pf.sv
`timescale 1ns/1ps

module tb_reset_sequencer_pf;

    typedef struct {
        int         cyc;
        logic [3:0] fab;
        logic       done;
        logic       pdb;
        logic [7:0] fab8;
        logic       done8;
        logic [1:0] cause;
    } exp_t;

    logic       clk = 1'b0;
    logic       ext_rst_n;
    logic       init_done;
    logic       lock;
    logic [1:0] lock2;
    logic [3:0] sw;
    logic [7:0] sw8;
    logic       pdb, pdb8, done, done8;
    logic [3:0] fab;
    logic [7:0] fab8;
`ifdef RSTSEQ_CAUSE_EN
    logic [1:0] cause, cause8;
`endif

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sbq[$];
    exp_t tbl[$];
    exp_t e;

    always #5 clk = ~clk;

    reset_sequencer_pf u_dut (
        .i_clk             (clk),
        .i_ext_rst_n       (ext_rst_n),
        .i_init_done       (init_done),
        .i_pll_lock        (lock),
        .i_sw_rst_req      (sw),
        .o_pll_powerdown_b (pdb),
        .o_fabric_reset_n  (fab),
        .o_rst_done        (done)
`ifdef RSTSEQ_CAUSE_EN
        ,
        .o_rst_cause       (cause)
`endif
    );

    reset_sequencer_pf #(.NUM_CH(8), .NUM_PLL(2), .STAGGER_CYCLES(0)) u_dut8 (
        .i_clk             (clk),
        .i_ext_rst_n       (ext_rst_n),
        .i_init_done       (init_done),
        .i_pll_lock        (lock2),
        .i_sw_rst_req      (sw8),
        .o_pll_powerdown_b (pdb8),
        .o_fabric_reset_n  (fab8),
        .o_rst_done        (done8)
`ifdef RSTSEQ_CAUSE_EN
        ,
        .o_rst_cause       (cause8)
`endif
    );

    function automatic exp_t mk(int c, logic [3:0] f, logic d, logic p,
                                logic [7:0] f8, logic d8, logic [1:0] ca);
        exp_t r;
        r.cyc = c; r.fab = f; r.done = d; r.pdb = p;
        r.fab8 = f8; r.done8 = d8; r.cause = ca;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic push_tbl();
        foreach (tbl[k]) sbq.push_back(tbl[k]);
        tbl.delete();
    endtask

    // Scoreboard: compare expectations due at this cycle, flag any that were skipped.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL seq_missed cyc=%0d now=%0d", e.cyc, cyc);
            end else begin
                total++;
                if ({fab, done, pdb, fab8, done8} !== {e.fab, e.done, e.pdb, e.fab8, e.done8}) begin
                    bad++;
                    $display("FAIL seq@%0d got fab=%b done=%b pdb=%b fab8=%h done8=%b want fab=%b done=%b pdb=%b fab8=%h done8=%b",
                             cyc, fab, done, pdb, fab8, done8, e.fab, e.done, e.pdb, e.fab8, e.done8);
                end
`ifdef RSTSEQ_CAUSE_EN
                total++;
                if (cause !== e.cause) begin
                    bad++;
                    $display("FAIL cause@%0d got=%b want=%b", cyc, cause, e.cause);
                end
`endif
            end
        end
    end

    initial begin
        ext_rst_n = 1'b0;
        init_done = 1'b1;
        lock      = 1'b1;
        lock2     = 2'b01;
        sw        = '0;
        sw8       = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs", {22'd0, fab, done, pdb, fab8}, 32'd0);
        chk("reset_dut8", {30'd0, pdb8, done8}, 32'd0);
`ifdef RSTSEQ_CAUSE_EN
        chk("reset_cause", {30'd0, cause}, 32'd0);
`endif

        // Power-up: sync 2, init 1, lock filter 4, hold 16 -> ch0 at 23, then +8 each.
        tbl.push_back(mk( 1, 4'b0000, 0, 0, 8'h00, 0, 2'b00));
        tbl.push_back(mk( 2, 4'b0000, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(22, 4'b0000, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(23, 4'b0001, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(30, 4'b0001, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(31, 4'b0011, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(38, 4'b0011, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(39, 4'b0111, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(46, 4'b0111, 0, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(47, 4'b1111, 1, 1, 8'h00, 0, 2'b00));
        push_tbl();
        ext_rst_n = 1'b1;
        run_to(50);

        // Soft reset ch2: request at 50, sync 2, low at 53 for exactly 16 cycles.
        tbl.push_back(mk(52, 4'b1111, 1, 1, 8'h00, 0, 2'b00));
        tbl.push_back(mk(53, 4'b1011, 1, 1, 8'h00, 0, 2'b10));
        tbl.push_back(mk(68, 4'b1011, 1, 1, 8'h00, 0, 2'b10));
        tbl.push_back(mk(69, 4'b1111, 1, 1, 8'h00, 0, 2'b10));
        push_tbl();
        sw[2] = 1'b1;
        run_to(56);
        sw[2] = 1'b0;
        run_to(75);

        // Soft reset ch0 with a second edge while held: count restarts at 86.
        tbl.push_back(mk( 78, 4'b1110, 1, 1, 8'h00, 0, 2'b10));
        tbl.push_back(mk( 94, 4'b1110, 1, 1, 8'h00, 0, 2'b10));
        tbl.push_back(mk(101, 4'b1110, 1, 1, 8'h00, 0, 2'b10));
        tbl.push_back(mk(102, 4'b1111, 1, 1, 8'h00, 0, 2'b10));
        push_tbl();
        sw[0] = 1'b1;
        run_to(79);
        sw[0] = 1'b0;
        run_to(83);
        sw[0] = 1'b1;
        run_to(105);
        sw[0] = 1'b0;
        run_to(110);

        // Lock loss in RUN, glitchy lock in WAIT_LOCK, re-lock, drop mid-release, re-lock.
        tbl.push_back(mk(112, 4'b1111, 1, 1, 8'h00, 0, 2'b10));
        tbl.push_back(mk(113, 4'b0000, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(125, 4'b0000, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(135, 4'b0000, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(144, 4'b0000, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(166, 4'b0000, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(167, 4'b0001, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(175, 4'b0011, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(179, 4'b0011, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(180, 4'b0000, 0, 1, 8'h00, 0, 2'b01));
        push_tbl();
        lock = 1'b0;
        run_to(115);
        for (int k = 0; k < 30; k++) begin
            lock = (k % 3 != 2);
            tick();
        end
        lock = 1'b1;
        run_to(177);
        lock = 1'b0;
        run_to(185);
        tbl.push_back(mk(206, 4'b0000, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(207, 4'b0001, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(215, 4'b0011, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(223, 4'b0111, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(230, 4'b0111, 0, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(231, 4'b1111, 1, 1, 8'h00, 0, 2'b01));
        push_tbl();
        lock = 1'b1;
        run_to(235);

        // 8-channel, 2-PLL, no stagger: all rise together once both locks qualify.
        tbl.push_back(mk(256, 4'b1111, 1, 1, 8'h00, 0, 2'b01));
        tbl.push_back(mk(257, 4'b1111, 1, 1, 8'hFF, 1, 2'b01));
        push_tbl();
        lock2 = 2'b11;
        run_to(260);

        // EXT_RST_N asserted in the middle of a soft reset on ch3.
        tbl.push_back(mk(263, 4'b0111, 1, 1, 8'hFF, 1, 2'b10));
        push_tbl();
        sw[3] = 1'b1;
        run_to(266);
        ext_rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {22'd0, fab, done, pdb, fab8}, 32'd0);
        chk("async_rst_dut8", {30'd0, pdb8, done8}, 32'd0);
`ifdef RSTSEQ_CAUSE_EN
        chk("async_rst_cause", {30'd0, cause}, 32'd0);
`endif
        chk("scoreboard_left", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
